// File: rtl/timer_control_logic_pkg.sv
// Shared definitions for the 16-bit timer/counter control core:
// register addresses, control/status bit positions, compare-output
// mode encodings, the bus handshake state type and the compare-output
// pin update rule.
package timer_control_logic_pkg;

   // Register addresses on the select/write/ack bus
   localparam logic [3:0] ADDR_TCCR  = 4'h1;
   localparam logic [3:0] ADDR_TCCR2 = 4'h2;
   localparam logic [3:0] ADDR_TCNT  = 4'h3;
   localparam logic [3:0] ADDR_OCR   = 4'h4;
   localparam logic [3:0] ADDR_ICR   = 4'h5;
   localparam logic [3:0] ADDR_TCST  = 4'h6;

   // TCCR bit positions; only bits [6:0] are implemented
   localparam int TCCR_EN     = 0;
   localparam int TCCR_DIR    = 1;
   localparam int TCCR_ICEN   = 2;
   localparam int TCCR_OCIE   = 3;
   localparam int TCCR_ICIE   = 4;
   localparam int TCCR_OM_LSB = 5;
   localparam int TCCR_OM_MSB = 6;
   localparam int TCCR_W      = 7;

   // TCST bit positions
   localparam int TCST_OCF  = 0;
   localparam int TCST_ICF  = 1;
   localparam int TCST_CCLR = 2;

   // Compare-output mode applied to the pin on a match event
   typedef enum logic [1:0] {
      OM_NONE   = 2'b00,
      OM_TOGGLE = 2'b01,
      OM_CLEAR  = 2'b10,
      OM_SET    = 2'b11
   } om_e;

   // Bus handshake states
   typedef enum logic [1:0] {
      BUS_IDLE = 2'b00,
      BUS_ACK  = 2'b01,
      BUS_HOLD = 2'b10
   } bus_state_e;

   // New compare-output pin level for a given mode and current level
   function automatic logic apply_om(input om_e om, input logic pin);
      logic res;
      case (om)
         OM_TOGGLE: res = ~pin;
         OM_CLEAR:  res = 1'b0;
         OM_SET:    res = 1'b1;
         default:   res = pin;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/timer_bus_fsm.sv
// Select/ack handshake for the timer register bus.
// Ports:
//   i_clk, i_rst  - clock, asynchronous active-high reset
//   i_select      - access request, held by the master until ack is seen
//   o_ack         - acknowledge, high in ACK and HOLD
//   o_access      - one-cycle strobe in the cycle that moves IDLE->ACK;
//                   register effects are committed on that edge
//   o_release     - one-cycle strobe in the cycle that moves HOLD->IDLE
module timer_bus_fsm
   import timer_control_logic_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_select,
   output logic o_ack,
   output logic o_access,
   output logic o_release
);

   bus_state_e r_state;
   bus_state_e w_state_nxt;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= BUS_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; ACK always lasts exactly one cycle
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         BUS_IDLE: begin
            if (i_select) w_state_nxt = BUS_ACK;
            else          w_state_nxt = BUS_IDLE;
         end
         BUS_ACK:  w_state_nxt = BUS_HOLD;
         BUS_HOLD: begin
            if (i_select) w_state_nxt = BUS_HOLD;
            else          w_state_nxt = BUS_IDLE;
         end
         default:  w_state_nxt = BUS_IDLE;
      endcase
   end

   // Output decode: ack comes straight from the state register
   always_comb begin
      o_ack     = 1'b0;
      o_access  = 1'b0;
      o_release = 1'b0;
      case (r_state)
         BUS_IDLE: o_access  = i_select;
         BUS_ACK:  o_ack     = 1'b1;
         BUS_HOLD: begin
            o_ack     = 1'b1;
            o_release = ~i_select;
         end
         default: begin
            o_ack     = 1'b0;
            o_access  = 1'b0;
            o_release = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/timer_control_logic.sv
// Register file and control core of the 16-bit timer/counter.
// Ports:
//   i_sysclk, i_sysrst            - clock, asynchronous active-high reset
//   i_bus_select/wr/reg_addr/data - register bus request
//   o_bus_data, o_bus_ack         - read data (0 outside ack) and acknowledge
//   o_prs_*                       - prescaler enable, load strobe, reload value
//   i_prs_sclk*                   - prescaled clock and its edge strobes
//   o_cnt_*, i_cnt_data           - counter control strobes and current value
//   o_cap_*, i_cap_*              - input-capture control, flag and value
//   o_int_flg, o_out_pin          - interrupt request and compare-output pin
module timer_control_logic
   import timer_control_logic_pkg::*;
(
   input  logic        i_sysclk,
   input  logic        i_sysrst,
   output logic        o_int_flg,
   output logic        o_out_pin,
   input  logic        i_bus_select,
   input  logic        i_bus_wr,
   input  logic [3:0]  i_reg_addr,
   input  logic [15:0] i_bus_data,
   output logic [15:0] o_bus_data,
   output logic        o_bus_ack,
   output logic        o_prs_en,
   output logic        o_prs_ld,
   output logic [7:0]  o_prs_ld_data,
   input  logic        i_prs_sclk,
   input  logic        i_prs_sclk_rise,
   input  logic        i_prs_sclk_fall,
   output logic        o_cnt_en,
   output logic        o_cnt_ld,
   output logic        o_cnt_dir,
   output logic        o_cnt_clr,
   output logic [15:0] o_cnt_ld_data,
   input  logic [15:0] i_cnt_data,
   output logic        o_cap_en,
   output logic        o_cap_clr,
   input  logic        i_cap_ic_flg,
   input  logic [15:0] i_cap_cnt_data
);

   logic              w_access;
   logic              w_release;
   logic              w_wr_acc;
   logic              w_wr_tccr;
   logic              w_wr_tccr2;
   logic              w_wr_tcnt;
   logic              w_wr_ocr;
   logic              w_wr_tcst;
   logic              w_eq;
   logic              w_match;
   logic              w_ocf_nxt;
   logic              w_out_nxt;
   logic              w_int_nxt;
   logic [TCCR_W-1:0] w_tccr_nxt;
   logic [15:0]       w_rd_mux;
   logic              w_unused_sclk;

   logic [TCCR_W-1:0] r_tccr;
   logic [7:0]        r_tccr2;
   logic [15:0]       r_ocr;
   logic [15:0]       r_cnt_ld_data;
   logic              r_ocf;
   logic              r_eq_q;
   logic              r_out_pin;
   logic              r_int_flg;
   logic              r_prs_ld;
   logic              r_cnt_ld;
   logic              r_cnt_clr;
   logic              r_cap_clr;
   logic [15:0]       r_bus_data;

   timer_bus_fsm u_bus_fsm (
      .i_clk     (i_sysclk),
      .i_rst     (i_sysrst),
      .i_select  (i_bus_select),
      .o_ack     (o_bus_ack),
      .o_access  (w_access),
      .o_release (w_release)
   );

   // Only the rising-edge strobe of the prescaled clock drives counting
   assign w_unused_sclk = i_prs_sclk ^ i_prs_sclk_fall;

   assign w_wr_acc   = w_access & i_bus_wr;
   assign w_wr_tccr  = w_wr_acc & (i_reg_addr == ADDR_TCCR);
   assign w_wr_tccr2 = w_wr_acc & (i_reg_addr == ADDR_TCCR2);
   assign w_wr_tcnt  = w_wr_acc & (i_reg_addr == ADDR_TCNT);
   assign w_wr_ocr   = w_wr_acc & (i_reg_addr == ADDR_OCR);
   assign w_wr_tcst  = w_wr_acc & (i_reg_addr == ADDR_TCST);

   // Match fires only on the first cycle of equality, so a counter parked
   // on OCR produces a single event
   assign w_eq    = (i_cnt_data == r_ocr);
   assign w_match = r_tccr[TCCR_EN] & w_eq & ~r_eq_q;

   // Control register next value
   always_comb begin
      if (w_wr_tccr) w_tccr_nxt = i_bus_data[TCCR_W-1:0];
      else           w_tccr_nxt = r_tccr;
   end

   // OCF next value: a match in the same cycle beats a software clear
   always_comb begin
      if (w_match)                                w_ocf_nxt = 1'b1;
      else if (w_wr_tcst && i_bus_data[TCST_OCF]) w_ocf_nxt = 1'b0;
      else                                        w_ocf_nxt = r_ocf;
   end

   // Compare-output pin next value
   always_comb begin
      if (w_match) w_out_nxt = apply_om(om_e'(r_tccr[TCCR_OM_MSB:TCCR_OM_LSB]), r_out_pin);
      else         w_out_nxt = r_out_pin;
   end

   // Interrupt uses post-update flag and enables so a flag clear or enable
   // change shows up together with the flag itself
   always_comb begin
      w_int_nxt = (w_ocf_nxt & w_tccr_nxt[TCCR_OCIE]) |
                  (i_cap_ic_flg & w_tccr_nxt[TCCR_ICIE]);
   end

   // Read data selection
   always_comb begin
      w_rd_mux = 16'h0000;
      case (i_reg_addr)
         ADDR_TCCR:  w_rd_mux = {9'h000, r_tccr};
         ADDR_TCCR2: w_rd_mux = {8'h00, r_tccr2};
         ADDR_TCNT:  w_rd_mux = i_cnt_data;
         ADDR_OCR:   w_rd_mux = r_ocr;
         ADDR_ICR:   w_rd_mux = i_cap_cnt_data;
         ADDR_TCST:  w_rd_mux = {14'h0000, i_cap_ic_flg, r_ocf};
         default:    w_rd_mux = 16'h0000;
      endcase
   end

   // Configuration registers, committed on the edge that enters ACK
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         r_tccr        <= {TCCR_W{1'b0}};
         r_tccr2       <= 8'h00;
         r_ocr         <= 16'h0000;
         r_cnt_ld_data <= 16'h0000;
      end else begin
         r_tccr <= w_tccr_nxt;
         if (w_wr_tccr2) r_tccr2       <= i_bus_data[7:0];
         if (w_wr_ocr)   r_ocr         <= i_bus_data;
         if (w_wr_tcnt)  r_cnt_ld_data <= i_bus_data;
      end
   end

   // Compare history, flags and output pin
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         r_eq_q    <= 1'b0;
         r_ocf     <= 1'b0;
         r_out_pin <= 1'b0;
         r_int_flg <= 1'b0;
      end else begin
         r_eq_q    <= w_eq;
         r_ocf     <= w_ocf_nxt;
         r_out_pin <= w_out_nxt;
         r_int_flg <= w_int_nxt;
      end
   end

   // One-cycle write strobes, high during the first ack cycle only
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         r_prs_ld  <= 1'b0;
         r_cnt_ld  <= 1'b0;
         r_cnt_clr <= 1'b0;
         r_cap_clr <= 1'b0;
      end else begin
         r_prs_ld  <= w_wr_tccr2;
         r_cnt_ld  <= w_wr_tcnt;
         r_cnt_clr <= w_wr_tcst & i_bus_data[TCST_CCLR];
         r_cap_clr <= w_wr_tcst & i_bus_data[TCST_ICF];
      end
   end

   // Read data is captured on entry to ACK and held until ack drops
   always_ff @(posedge i_sysclk or posedge i_sysrst) begin
      if (i_sysrst) begin
         r_bus_data <= 16'h0000;
      end else if (w_access) begin
         r_bus_data <= i_bus_wr ? 16'h0000 : w_rd_mux;
      end else if (w_release) begin
         r_bus_data <= 16'h0000;
      end
   end

   assign o_bus_data    = r_bus_data;
   assign o_int_flg     = r_int_flg;
   assign o_out_pin     = r_out_pin;
   assign o_prs_en      = r_tccr[TCCR_EN];
   assign o_prs_ld      = r_prs_ld;
   assign o_prs_ld_data = r_tccr2;
   assign o_cnt_en      = r_tccr[TCCR_EN] & i_prs_sclk_rise;
   assign o_cnt_ld      = r_cnt_ld;
   assign o_cnt_dir     = r_tccr[TCCR_DIR];
   assign o_cnt_clr     = r_cnt_clr;
   assign o_cnt_ld_data = r_cnt_ld_data;
   assign o_cap_en      = r_tccr[TCCR_EN] & r_tccr[TCCR_ICEN];
   assign o_cap_clr     = r_cap_clr;

endmodule

// File: tb/tb_timer_control_logic.sv
// Self-checking bench for timer_control_logic: directed steps followed by
// randomized bus traffic and counter/capture activity, all compared every
// cycle against a register-map level reference model.
module tb_timer_control_logic;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  addr = 4'h0;
   logic [15:0] wdata = 16'h0000;
   logic        sclk = 1'b0;
   logic        rise = 1'b0;
   logic        fall = 1'b0;
   logic [15:0] cnt = 16'h0000;
   logic        icflg = 1'b0;
   logic [15:0] capd = 16'h0000;

   logic        int_flg, out_pin, ack, prs_en, prs_ld, cnt_en, cnt_ld, cnt_dir;
   logic        cnt_clr, cap_en, cap_clr;
   logic [15:0] rdata, cnt_ld_data;
   logic [7:0]  prs_ld_data;

   timer_control_logic dut (
      .i_sysclk(clk), .i_sysrst(rst), .o_int_flg(int_flg), .o_out_pin(out_pin),
      .i_bus_select(sel), .i_bus_wr(wr), .i_reg_addr(addr), .i_bus_data(wdata),
      .o_bus_data(rdata), .o_bus_ack(ack), .o_prs_en(prs_en), .o_prs_ld(prs_ld),
      .o_prs_ld_data(prs_ld_data), .i_prs_sclk(sclk), .i_prs_sclk_rise(rise),
      .i_prs_sclk_fall(fall), .o_cnt_en(cnt_en), .o_cnt_ld(cnt_ld),
      .o_cnt_dir(cnt_dir), .o_cnt_clr(cnt_clr), .o_cnt_ld_data(cnt_ld_data),
      .i_cnt_data(cnt), .o_cap_en(cap_en), .o_cap_clr(cap_clr),
      .i_cap_ic_flg(icflg), .i_cap_cnt_data(capd)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   // Reference model: register images and observable outputs
   logic [15:0] m_tccr, m_tccr2, m_ocr, m_ld_data, m_rdata;
   logic        m_ocf, m_out, m_int, m_prev_eq, m_ack;
   logic        m_prs_ld, m_cnt_ld, m_cnt_clr, m_cap_clr;
   logic        acc_now = 1'b0;
   logic        rel_now = 1'b0;
   logic        rand_env = 1'b0;
   logic [15:0] obs_rd;
   logic        obs_ack1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_tccr = 16'h0000; m_tccr2 = 16'h0000; m_ocr = 16'h0000; m_ld_data = 16'h0000;
      m_rdata = 16'h0000; m_ocf = 1'b0; m_out = 1'b0; m_int = 1'b0; m_prev_eq = 1'b0;
      m_ack = 1'b0; m_prs_ld = 1'b0; m_cnt_ld = 1'b0; m_cnt_clr = 1'b0; m_cap_clr = 1'b0;
   endtask

   function automatic logic [15:0] reg_view(input logic [3:0] a);
      case (a)
         4'h1:    return m_tccr;
         4'h2:    return m_tccr2;
         4'h3:    return cnt;
         4'h4:    return m_ocr;
         4'h5:    return capd;
         4'h6:    return {14'h0000, icflg, m_ocf};
         default: return 16'h0000;
      endcase
   endfunction

   // One clock edge of the model, using the inputs present at that edge
   task automatic model_edge();
      logic [15:0] old_tccr;
      logic        eq, match, ocf_clear;
      old_tccr  = m_tccr;
      eq        = (cnt == m_ocr);
      match     = old_tccr[0] && eq && !m_prev_eq;
      m_prev_eq = eq;
      ocf_clear = 1'b0;
      m_prs_ld = 1'b0; m_cnt_ld = 1'b0; m_cnt_clr = 1'b0; m_cap_clr = 1'b0;
      if (acc_now) m_rdata = wr ? 16'h0000 : reg_view(addr);
      else if (rel_now) m_rdata = 16'h0000;
      if (acc_now && wr) begin
         case (addr)
            4'h1: m_tccr = wdata & 16'h007F;
            4'h2: begin m_tccr2 = wdata & 16'h00FF; m_prs_ld = 1'b1; end
            4'h3: begin m_ld_data = wdata; m_cnt_ld = 1'b1; end
            4'h4: m_ocr = wdata;
            4'h6: begin
               ocf_clear = wdata[0]; m_cap_clr = wdata[1]; m_cnt_clr = wdata[2];
            end
            default: ;
         endcase
      end
      if (match) begin
         m_ocf = 1'b1;
         case (old_tccr[6:5])
            2'b01:   m_out = ~m_out;
            2'b10:   m_out = 1'b0;
            2'b11:   m_out = 1'b1;
            default: ;
         endcase
      end else if (ocf_clear) begin
         m_ocf = 1'b0;
      end
      m_int = (m_ocf && m_tccr[3]) || (icflg && m_tccr[4]);
      if (acc_now) m_ack = 1'b1;
      else if (rel_now) m_ack = 1'b0;
   endtask

   task automatic check_all();
      chk("ack", {15'h0, ack}, {15'h0, m_ack});
      chk("bus_data", rdata, m_rdata);
      chk("prs_en", {15'h0, prs_en}, {15'h0, m_tccr[0]});
      chk("prs_ld", {15'h0, prs_ld}, {15'h0, m_prs_ld});
      chk("prs_ld_data", {8'h00, prs_ld_data}, m_tccr2);
      chk("cnt_en", {15'h0, cnt_en}, {15'h0, m_tccr[0] & rise});
      chk("cnt_ld", {15'h0, cnt_ld}, {15'h0, m_cnt_ld});
      chk("cnt_dir", {15'h0, cnt_dir}, {15'h0, m_tccr[1]});
      chk("cnt_clr", {15'h0, cnt_clr}, {15'h0, m_cnt_clr});
      chk("cnt_ld_data", cnt_ld_data, m_ld_data);
      chk("cap_en", {15'h0, cap_en}, {15'h0, m_tccr[0] & m_tccr[2]});
      chk("cap_clr", {15'h0, cap_clr}, {15'h0, m_cap_clr});
      chk("out_pin", {15'h0, out_pin}, {15'h0, m_out});
      chk("int_flg", {15'h0, int_flg}, {15'h0, m_int});
   endtask

   task automatic drive_env();
      int r;
      r = $urandom_range(0, 3);
      case (r)
         0:       cnt = m_ocr;
         1:       cnt = m_ocr + 16'h0001;
         2:       cnt = m_ocr - 16'h0001;
         default: cnt = 16'($urandom);
      endcase
      rise = 1'($urandom);
      sclk = 1'($urandom);
      fall = 1'($urandom);
      capd = 16'($urandom);
      if (m_cap_clr) icflg = 1'b0;
      else if (!icflg) icflg = ($urandom_range(0, 7) == 0);
   endtask

   task automatic tick();
      if (rand_env) drive_env();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   // Full bus access; select stays high for 'hold' extra cycles after ack
   task automatic bus(input logic w, input logic [3:0] a, input logic [15:0] d, input int hold);
      sel = 1'b1; wr = w; addr = a; wdata = d;
      acc_now = 1'b1;
      tick();
      acc_now = 1'b0;
      obs_rd = rdata;
      obs_ack1 = ack;
      for (int i = 0; i < hold; i++) tick();
      sel = 1'b0;
      if (hold == 0) tick();
      rel_now = 1'b1;
      tick();
      rel_now = 1'b0;
   endtask

   initial begin
      model_reset();
      #1;
      check_all();
      #59 rst = 1'b0;

      // Enable and read back
      bus(1'b1, 4'h1, 16'h0001, 0);
      chk("ack_first_cycle", {15'h0, obs_ack1}, 16'h0001);
      chk("prs_en_on", {15'h0, prs_en}, 16'h0001);
      bus(1'b0, 4'h1, 16'h0000, 0);
      chk("tccr_readback", obs_rd, 16'h0001);

      // Prescaler reload and counter load
      bus(1'b1, 4'h2, 16'h0003, 0);
      chk("prs_ld_data_3", {8'h00, prs_ld_data}, 16'h0003);
      bus(1'b1, 4'h3, 16'h0007, 0);
      chk("cnt_ld_data_7", cnt_ld_data, 16'h0007);

      // Compare match with toggle mode
      bus(1'b1, 4'h4, 16'h000F, 0);
      bus(1'b1, 4'h1, 16'h0029, 0);
      for (int c = 0; c <= 16'h11; c++) begin
         cnt = 16'(c);
         tick();
      end
      chk("match_pin", {15'h0, out_pin}, 16'h0001);
      chk("match_int", {15'h0, int_flg}, 16'h0001);
      bus(1'b0, 4'h6, 16'h0000, 0);
      chk("tcst_ocf", obs_rd, 16'h0001);
      bus(1'b1, 4'h6, 16'h0001, 0);
      chk("ocf_cleared_int", {15'h0, int_flg}, 16'h0000);

      // Input capture
      bus(1'b1, 4'h1, 16'h0015, 0);
      chk("cap_en_on", {15'h0, cap_en}, 16'h0001);
      capd = 16'hBEEF;
      icflg = 1'b1;
      tick();
      tick();
      chk("icf_int", {15'h0, int_flg}, 16'h0001);
      bus(1'b0, 4'h5, 16'h0000, 0);
      chk("icr_read", obs_rd, 16'hBEEF);
      bus(1'b1, 4'h6, 16'h0002, 0);
      icflg = 1'b0;
      tick();

      // Read-only ICR, multi-bit TCST write with a long select
      bus(1'b1, 4'h5, 16'h001F, 0);
      bus(1'b0, 4'h5, 16'h0000, 0);
      chk("icr_unchanged", obs_rd, 16'hBEEF);
      bus(1'b1, 4'h6, 16'h003F, 5);

      // Reset in the middle of an ACK cycle
      sel = 1'b1; wr = 1'b1; addr = 4'h2; wdata = 16'h00AA;
      acc_now = 1'b1;
      tick();
      acc_now = 1'b0;
      #1 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      sel = 1'b0;
      #2 rst = 1'b0;
      tick();

      // Randomized traffic
      rand_env = 1'b1;
      for (int it = 0; it < 400; it++) begin
         int op;
         logic [15:0] d;
         op = $urandom_range(0, 9);
         d  = 16'($urandom);
         if (op < 5) begin
            tick();
         end else if (op < 8) begin
            if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
            bus(1'b1, 4'($urandom_range(0, 8)), d, $urandom_range(0, 3));
         end else begin
            bus(1'b0, 4'($urandom_range(0, 15)), d, $urandom_range(0, 3));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
